aes_byte_loader: RTL and testbench
==================================

Name: aes_byte_loader

Overview:
Input-side counterpart to the AES top-level and its display path. The top-level currently consumes a hard-wired key and plaintext and drives results out to the 7-segment display; this block supplies those operands instead. It receives a byte stream over a valid/ready handshake and assembles an Nk-word cipher key and 128-bit data blocks. It then presents each block to the cipher/decipher cores over a valid/ready handshake. The key is retained across blocks until a new key load is requested.

Parameters:
Nk, 4, key length in 32-bit words (4/6/8 for AES-128/192/256)
NB_KEY, 4*Nk, key bytes per key load (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
key_req  in  1  request a new key load; sampled only in IDLE
in_byte  in  8  stream byte; first byte is the most-significant byte
in_par  in  1  odd-parity bit for in_byte; used only when AES_LOADER_PARITY_EN is defined
in_valid  in  1  in_byte/in_par valid
in_ready  out  1  loader accepts in_byte this cycle
key_out  out  32*Nk  assembled key; byte 0 in bits [32*Nk-1:32*Nk-8]
key_valid  out  1  key_out holds a complete key
blk_out  out  128  assembled data block; byte 0 in [127:120]
blk_valid  out  1  blk_out valid
blk_ready  in  1  core accepts blk_out
busy  out  1  state != IDLE
err  out  1  sticky parity-error flag

Behaviour:
- A byte is transferred on a rising clk edge with in_valid && in_ready.
- A block is transferred on a rising clk edge with blk_valid && blk_ready.
- Reset (reset=0, async) forces the following, at any time including mid-load or with blk_valid high:
  - state=IDLE, byte counter=0
  - key_out=0, blk_out=0
  - key_valid=0, blk_valid=0, in_ready=0, busy=0, err=0
- States and transitions:
  - IDLE:
    - key_req=1 → LOAD_KEY; clear key_valid the same edge.
    - Otherwise, if key_valid=1, in_ready=1. An accepted byte is stored as data byte 0 and state → LOAD_DATA with count=1.
    - Otherwise (no key), in_ready=0.
  - LOAD_KEY:
    - in_ready=1. Each accepted byte shifts into key_out from the LSB end, so earlier bytes move toward the MSB.
    - On the NB_KEY-th byte: key_valid=1 on the next cycle, count=0, → IDLE.
  - LOAD_DATA:
    - in_ready=1. Bytes shift into blk_out the same way.
    - On the 16th byte: → PRESENT, and blk_valid=1 in the cycle after that handshake (1-cycle latency).
  - PRESENT:
    - in_ready=0. blk_out and blk_valid are held stable until blk_ready=1.
    - On transfer: blk_valid=0 next cycle, → IDLE.
- Counter is 5 bits and wraps to 0 at the end of each load; no modular arithmetic beyond that.
- key_req outside IDLE is ignored. It is not latched; the requester holds it until busy=0.
- in_valid with in_ready=0 holds the byte (no drop). The sender must keep in_byte stable until the handshake.
- blk_ready in any state other than PRESENT is ignored.
- If key_req=1 and in_valid=1 in IDLE on the same cycle, key_req wins and in_ready=0 that cycle.
- key_out changes only during LOAD_KEY. The core must not start a block while key_valid=0.

Optional Feature:
Macro: AES_LOADER_PARITY_EN
- Defined:
  - Each accepted byte is checked for odd parity: ^{in_byte,in_par} must equal 1.
  - On a mismatch the byte is still consumed, then the load is aborted:
    - err=1 (sticky until reset)
    - count=0, → IDLE
    - key_valid=0 if the abort happened in LOAD_KEY; blk_valid stays 0
  - A partially loaded key is never marked valid.
- Not defined: in_par is ignored and err is tied to 0.

Decomposition:
- Shared package aes_pkg:
  - state encoding typedef (IDLE, LOAD_KEY, LOAD_DATA, PRESENT)
  - BLK_BYTES=16
  - function nk_to_nr(Nk) = Nk+6, used by the AES_N-level wrapper that instantiates this block
- One natural sub-module: aes_shift_collector, a parameterized byte-shift register with a count and full flag. It is instantiated twice: key width 32*Nk and block width 128.
- The FSM stays in aes_byte_loader.

Test Plan:
1. Key load, Nk=4:
   - Stimulus: key_req, then bytes 00,01..0f, then data bytes 00,11,22..ff with in_valid continuous and blk_ready=1.
   - Required: key_out=000102030405060708090a0b0c0d0e0f with key_valid=1; blk_out=00112233445566778899aabbccddeeff with blk_valid a single-cycle pulse one cycle after the 16th byte.
2. Key load, Nk=8:
   - Stimulus: 32 bytes 00..1f.
   - Required: key_out=000102..1e1f; key_valid rises exactly 1 cycle after the 32nd handshake.
3. Backpressure:
   - Stimulus: blk_ready=0 for 5 cycles after blk_valid, with in_valid held high.
   - Required: blk_out stable, in_ready=0 throughout; after blk_ready=1, blk_valid drops and the next byte is accepted in IDLE.
4. No key / simultaneous requests:
   - Stimulus: data bytes offered after reset with no key.
   - Required: in_ready=0 and no state change.
   - Stimulus: key_req and in_valid together in IDLE.
   - Required: key_req wins (→ LOAD_KEY).
5. Reset mid-operation:
   - Stimulus: reset=0 asserted after 7 data bytes.
   - Required: all outputs 0 asynchronously; after release, a fresh 16-byte load produces a correct block.
6. Parity error (AES_LOADER_PARITY_EN defined):
   - Stimulus: bad parity on key byte 3.
   - Required: err=1, key_valid=0, state=IDLE; a subsequent good key load completes while err stays 1.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES operand loader path.
package aes_pkg;
    typedef enum logic [1:0] {IDLE, LOAD_KEY, LOAD_DATA, PRESENT} state_t;
    localparam int BLK_BYTES = 16;
    function automatic int nk_to_nr(input int nk);
        return nk + 6;
    endfunction
endpackage

// File: rtl/aes_shift_collector.sv
// aes_shift_collector: byte-wide shift register that assembles NBYTES bytes MSB-first, with byte count and full flag.
module aes_shift_collector #(
    parameter int NBYTES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                shift,
    input  logic [7:0]          din,
    output logic [8*NBYTES-1:0] data,
    output logic [4:0]          count,
    output logic                full
);
    // full flags that the byte being shifted now is the last one of the load
    assign full = count == 5'(NBYTES - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            data  <= '0;
            count <= '0;
        end else begin
            if (shift) data <= {data[8*NBYTES-9:0], din};
            if (clr) count <= '0;
            else if (shift) count <= full ? 5'd0 : count + 5'd1;
        end
endmodule

// File: rtl/aes_byte_loader.sv
// aes_byte_loader: assembles an Nk-word key and 128-bit blocks from a byte stream and presents blocks to the AES cores.
// Optional odd-parity check on each byte when AES_LOADER_PARITY_EN is defined.
module aes_byte_loader
    import aes_pkg::*;
#(
    parameter int Nk = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            key_req,
    input  logic [7:0]      in_byte,
    input  logic            in_par,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [32*Nk-1:0] key_out,
    output logic            key_valid,
    output logic [127:0]    blk_out,
    output logic            blk_valid,
    input  logic            blk_ready,
    output logic            busy,
    output logic            err
);
    localparam int NB_KEY = 4 * Nk;
    state_t state;
    logic acc, par_ok, abort, key_full, blk_full;
    logic [4:0] key_cnt_unused, blk_cnt_unused;
    assign acc   = in_valid && in_ready;
    assign abort = acc && !par_ok;
    assign busy  = state != IDLE;
    // key_req has priority over a data byte offered in IDLE
    always_comb
        in_ready = (state == LOAD_KEY) || (state == LOAD_DATA) ||
                   (state == IDLE && key_valid && !key_req);
`ifdef AES_LOADER_PARITY_EN
    assign par_ok = ^{in_byte, in_par};
    always_ff @(posedge clk or negedge reset)
        if (!reset) err <= 1'b0;
        else if (abort) err <= 1'b1;
`else
    logic par_unused;
    assign par_ok     = 1'b1;
    assign par_unused = in_par;
    assign err        = 1'b0;
`endif
    aes_shift_collector #(.NBYTES(NB_KEY)) u_key (
        .clk(clk), .reset(reset), .clr(abort), .shift(acc && state == LOAD_KEY),
        .din(in_byte), .data(key_out), .count(key_cnt_unused), .full(key_full)
    );
    aes_shift_collector #(.NBYTES(BLK_BYTES)) u_blk (
        .clk(clk), .reset(reset), .clr(abort), .shift(acc && state != LOAD_KEY),
        .din(in_byte), .data(blk_out), .count(blk_cnt_unused), .full(blk_full)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            key_valid <= 1'b0;
            blk_valid <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (key_req) begin
                        state     <= LOAD_KEY;
                        key_valid <= 1'b0;
                    end else if (acc && par_ok) state <= LOAD_DATA;
                LOAD_KEY:
                    if (abort) state <= IDLE;
                    else if (acc && key_full) begin
                        state     <= IDLE;
                        key_valid <= 1'b1;
                    end
                LOAD_DATA:
                    if (abort) state <= IDLE;
                    else if (acc && blk_full) begin
                        state     <= PRESENT;
                        blk_valid <= 1'b1;
                    end
                PRESENT:
                    if (blk_ready) begin
                        state     <= IDLE;
                        blk_valid <= 1'b0;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_aes_byte_loader.sv
// tb_aes_byte_loader: table-driven, directed and randomized checks of aes_byte_loader (Nk=4 and Nk=8).
module tb_aes_byte_loader;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic key_req = 0, in_valid = 0, in_par = 0, blk_ready = 0;
    logic [7:0] in_byte = 0;
    logic in_ready, key_valid, blk_valid, busy, err;
    logic [127:0] key_out, blk_out;

    logic key_req8 = 0, in_valid8 = 0, in_par8 = 0, blk_ready8 = 0;
    logic [7:0] in_byte8 = 0;
    logic in_ready8, key_valid8, blk_valid8, busy8, err8;
    logic [255:0] key_out8;
    logic [127:0] blk_out8;

    aes_byte_loader #(.Nk(4)) dut (
        .clk(clk), .reset(reset), .key_req(key_req), .in_byte(in_byte), .in_par(in_par),
        .in_valid(in_valid), .in_ready(in_ready), .key_out(key_out), .key_valid(key_valid),
        .blk_out(blk_out), .blk_valid(blk_valid), .blk_ready(blk_ready), .busy(busy), .err(err)
    );
    aes_byte_loader #(.Nk(8)) dut8 (
        .clk(clk), .reset(reset), .key_req(key_req8), .in_byte(in_byte8), .in_par(in_par8),
        .in_valid(in_valid8), .in_ready(in_ready8), .key_out(key_out8), .key_valid(key_valid8),
        .blk_out(blk_out8), .blk_valid(blk_valid8), .blk_ready(blk_ready8), .busy(busy8), .err(err8)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit bad = 0);
        int n;
        in_byte  = b;
        in_par   = bad ? ^b : ~^b;
        in_valid = 1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
        end
        if (n == 50) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic send8(input logic [7:0] b);
        int n;
        in_byte8  = b;
        in_par8   = ~^b;
        in_valid8 = 1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready8 === 1'b1) break;
        end
        if (n == 50) chk("in_ready8_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic req_key();
        key_req = 1;
        @(posedge clk); #1;
        key_req = 0;
    endtask

    task automatic load_key(input logic [127:0] k);
        req_key();
        for (int i = 0; i < 16; i++) send(k[127-8*i -: 8]);
        in_valid = 0;
        chk("load_key_valid", key_valid, 1);
        chk("load_key_out", key_out, k);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] dat;
    } vec_t;
    vec_t tbl[4];

    initial begin
        logic [127:0] k, exp_blk;
        logic [255:0] exp8;
        logic [7:0] q[16];
        tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff};
        tbl[1] = '{128'hffffffffffffffffffffffffffffffff, 128'h0123456789abcdeffedcba9876543210};
        tbl[2] = '{128'h55aa55aa55aa55aa55aa55aa55aa55aa, 128'h00000000000000000000000000000001};
        tbl[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734};

        #1 reset = 0;
        #1;
        chk("rst_key_out", key_out, 0);
        chk("rst_blk_out", blk_out, 0);
        chk("rst_flags", {key_valid, blk_valid, in_ready, busy, err}, 0);
        chk("rst8_flags", {key_valid8, blk_valid8, in_ready8, busy8}, 0);
        @(posedge clk); #1 reset = 1;

        // no key loaded: offered data must be refused
        in_byte = 8'h55; in_par = ~^in_byte; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("nokey_in_ready", in_ready, 0);
            chk("nokey_busy", busy, 0);
        end
        @(posedge clk); #1 in_valid = 0;

        // Nk=8 key load
        key_req8 = 1; @(posedge clk); #1 key_req8 = 0;
        exp8 = '0;
        for (int i = 0; i < 32; i++) begin
            send8(8'(i));
            exp8[255-8*i -: 8] = 8'(i);
            if (i == 30) chk("k8_valid_early", key_valid8, 0);
        end
        in_valid8 = 0;
        chk("k8_valid", key_valid8, 1);
        chk("k8_key_out", key_out8, exp8);

        // table: key then data with in_valid continuous, blk_ready high
        blk_ready = 1;
        for (int v = 0; v < 4; v++) begin
            req_key();
            for (int i = 0; i < 16; i++) send(tbl[v].key[127-8*i -: 8]);
            chk("tbl_key_valid", key_valid, 1);
            chk("tbl_key_out", key_out, tbl[v].key);
            for (int i = 0; i < 15; i++) send(tbl[v].dat[127-8*i -: 8]);
            chk("tbl_blk_valid_early", blk_valid, 0);
            send(tbl[v].dat[7:0]);
            in_valid = 0;
            chk("tbl_blk_valid", blk_valid, 1);
            chk("tbl_blk_out", blk_out, tbl[v].dat);
            @(posedge clk); #1;
            chk("tbl_blk_pulse_end", blk_valid, 0);
            chk("tbl_idle", busy, 0);
        end
        blk_ready = 0;

        // key_req and in_valid together in IDLE: key_req wins
        key_req = 1; in_byte = 8'ha0; in_par = ~^in_byte; in_valid = 1;
        @(negedge clk);
        chk("simul_in_ready", in_ready, 0);
        @(posedge clk); #1 key_req = 0;
        chk("simul_busy", busy, 1);
        chk("simul_key_valid", key_valid, 0);
        for (int i = 0; i < 16; i++) send(8'ha0 + 8'(i));
        in_valid = 0;
        chk("simul_key_out", key_out, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);

        // backpressure on the block output
        for (int i = 0; i < 16; i++) send(tbl[3].dat[127-8*i -: 8]);
        in_byte = 8'h77; in_par = ~^in_byte;
        chk("bp_blk_valid", blk_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_blk_out", blk_out, tbl[3].dat);
            chk("bp_blk_valid_hold", blk_valid, 1);
        end
        blk_ready = 1;
        @(posedge clk); #1 blk_ready = 0;
        chk("bp_drop", blk_valid, 0);
        chk("bp_idle", busy, 0);
        send(8'h77);
        chk("bp_next_accepted", busy, 1);

        // reset after 7 data bytes
        for (int i = 1; i < 7; i++) send(8'(i));
        in_valid = 0;
        #3 reset = 0;
        #1;
        chk("mid_rst_key_out", key_out, 0);
        chk("mid_rst_blk_out", blk_out, 0);
        chk("mid_rst_flags", {key_valid, blk_valid, in_ready, busy, err}, 0);
        @(posedge clk); #1 reset = 1;
        load_key(tbl[0].key);
        blk_ready = 1;
        for (int i = 0; i < 16; i++) send(tbl[0].dat[127-8*i -: 8]);
        in_valid = 0;
        chk("post_rst_blk_valid", blk_valid, 1);
        chk("post_rst_blk_out", blk_out, tbl[0].dat);
        @(posedge clk); #1 blk_ready = 0;

        // randomized keys and blocks with input gaps and output stalls
        for (int r = 0; r < 6; r++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            load_key(k);
            for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
                for (int i = 0; i < 16; i++) q[i] = 8'($urandom());
                for (int i = 0; i < 16; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 0;
                        repeat ($urandom_range(1, 2)) @(posedge clk);
                        #1;
                    end
                    send(q[i]);
                end
                in_valid = 0;
                exp_blk = '0;
                for (int i = 0; i < 16; i++) exp_blk[127-8*i -: 8] = q[i];
                chk("rnd_blk_valid", blk_valid, 1);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                @(negedge clk);
                chk("rnd_blk_out", blk_out, exp_blk);
                chk("rnd_blk_held", blk_valid, 1);
                blk_ready = 1;
                @(posedge clk); #1 blk_ready = 0;
                chk("rnd_blk_done", blk_valid, 0);
                chk("rnd_key_kept", key_out, k);
            end
        end

`ifdef AES_LOADER_PARITY_EN
        req_key();
        for (int i = 0; i < 3; i++) send(8'(i));
        send(8'h03, 1);
        in_valid = 0;
        chk("par_err", err, 1);
        chk("par_key_valid", key_valid, 0);
        chk("par_idle", busy, 0);
        load_key(tbl[1].key);
        chk("par_err_sticky", err, 1);
`else
        chk("err_tied_low", err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
